// File: rtl/parameter_def.sv
// Shared constants and state type for the 16-QAM receive path.
// Consumed by qam_deframer and its byte FIFO.
package parameter_def;

  localparam logic [15:0] QAM_SYNC_WORD   = 16'hEB90;
  localparam int          QAM_FRAME_BYTES = 64;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    SYNC_CHK
  } deframer_state_e;

endpackage

// File: rtl/qam_byte_fifo.sv
// Show-ahead byte FIFO with a registered output stage.
// Total capacity (memory plus output register) is DEPTH entries.
module qam_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          ovalid;
  logic [W-1:0]  odata;

  logic          do_pop;
  logic          do_push;
  logic          load;
  logic [AW:0]   total;

  always_comb begin
    do_pop  = pop && ovalid;
    total   = cnt + {{AW{1'b0}}, ovalid};
    full    = (total == (AW+1)'(DEPTH));
    do_push = push && (!full || do_pop);
    load    = (cnt != '0) && (!ovalid || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovalid <= 1'b0;
      odata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        odata  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      ovalid <= load || (ovalid && !do_pop);
      cnt    <= cnt + (AW+1)'(do_push) - (AW+1)'(load);
    end
  end

  assign rdata = odata;
  assign empty = !ovalid;

endmodule

// File: rtl/qam_deframer.sv
// Sync search, frame lock and nibble-to-byte packing for the 16-QAM demod.
// Optional counters via `define QAM_DEFRAMER_STATS_EN.
module qam_deframer
  import parameter_def::*;
#(
  parameter logic [15:0] SYNC_WORD   = QAM_SYNC_WORD,
  parameter int          FRAME_BYTES = QAM_FRAME_BYTES,
  parameter int          MISS_MAX    = 3,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        din_valid,
  input  logic [3:0]  din,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        locked,
  output logic        ovf
`ifdef QAM_DEFRAMER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] sync_loss_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);
  localparam logic [2:0] MISS_LIM = 3'(MISS_MAX);

  deframer_state_e state_q, state_d;
  logic [15:0] sh_q;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic        nib_phase_q, nib_phase_d;
  logic [1:0]  nib_cnt_q, nib_cnt_d;
  logic [2:0]  miss_q, miss_d;
  logic        push, push_last, sync_loss;
  logic        sync_hit;
  logic        fifo_full, fifo_empty, pop, drop;
  logic [8:0]  fifo_rdata;
  logic        ovf_q;

  assign sync_hit = ({sh_q[11:0], din} == SYNC_WORD);

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    byte_cnt_d  = byte_cnt_q;
    nib_phase_d = nib_phase_q;
    nib_cnt_d   = nib_cnt_q;
    miss_d      = miss_q;
    push        = 1'b0;
    push_last   = 1'b0;
    sync_loss   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (sync_hit) begin
            state_d     = PAYLOAD;
            byte_cnt_d  = '0;
            nib_phase_d = 1'b0;
            miss_d      = '0;
          end
        end
        PAYLOAD: begin
          if (!nib_phase_q) begin
            hi_d        = din;
            nib_phase_d = 1'b1;
          end else begin
            nib_phase_d = 1'b0;
            push        = 1'b1;
            push_last   = (byte_cnt_q == LAST_IDX);
            if (push_last) begin
              state_d    = SYNC_CHK;
              nib_cnt_d  = '0;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end
        SYNC_CHK: begin
          nib_cnt_d = nib_cnt_q + 2'd1;
          if (nib_cnt_q == 2'd3) begin
            unique case (1'b1)
              sync_hit: begin
                miss_d  = '0;
                state_d = PAYLOAD;
              end
              ((miss_q + 3'd1) == MISS_LIM): begin
                miss_d    = '0;
                state_d   = HUNT;
                sync_loss = 1'b1;
              end
              default: begin
                // flywheel: keep framing through an isolated bad sync
                miss_d  = miss_q + 3'd1;
                state_d = PAYLOAD;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q     <= HUNT;
      sh_q        <= '0;
      hi_q        <= '0;
      byte_cnt_q  <= '0;
      nib_phase_q <= 1'b0;
      nib_cnt_q   <= '0;
      miss_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      byte_cnt_q  <= byte_cnt_d;
      nib_phase_q <= nib_phase_d;
      nib_cnt_q   <= nib_cnt_d;
      miss_q      <= miss_d;
      ovf_q       <= drop;
      if (din_valid) sh_q <= {sh_q[11:0], din};
    end
  end

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign drop = push && fifo_full && !pop;

  qam_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (axi_clk),
    .rst   (axi_rst),
    .push  (push),
    .wdata ({push_last, hi_q, din}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_rdata[7:0];
  assign m_axis_tlast  = fifo_rdata[8];
  assign locked        = (state_q != HUNT);
  assign ovf           = ovf_q;

`ifdef QAM_DEFRAMER_STATS_EN
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      frame_cnt     <= '0;
      sync_loss_cnt <= '0;
      drop_cnt      <= '0;
    end else begin
      if (push && push_last && !drop && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (sync_loss && sync_loss_cnt != 16'hFFFF)
        sync_loss_cnt <= sync_loss_cnt + 16'd1;
      if (ovf_q && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qam_deframer.sv
// Directed bench for qam_deframer: lock, flywheel, overflow, reset, gaps.
// Output bytes are captured on the falling edge and compared to a sent-byte list.
module tb_qam_deframer;
  import parameter_def::*;

  logic       axi_clk = 1'b0;
  logic       axi_rst;
  logic       din_valid;
  logic [3:0] din;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       locked;
  logic       ovf;
`ifdef QAM_DEFRAMER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] sync_loss_cnt;
  logic [15:0] drop_cnt;
`endif

  qam_deframer dut (
    .axi_clk       (axi_clk),
    .axi_rst       (axi_rst),
    .din_valid     (din_valid),
    .din           (din),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .locked        (locked),
    .ovf           (ovf)
`ifdef QAM_DEFRAMER_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .sync_loss_cnt (sync_loss_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  always #5 axi_clk = ~axi_clk;

  int checks   = 0;
  int failures = 0;
  int gap      = 0;
  int ovf_cnt  = 0;
  logic [7:0] rx_data[$];
  logic       rx_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  always @(negedge axi_clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_last.push_back(m_axis_tlast);
    end
    if (ovf) ovf_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    repeat (gap) @(posedge axi_clk);
    #1;
    din_valid = 1'b1;
    din       = n;
    @(posedge axi_clk);
    #1;
    din_valid = 1'b0;
    din       = 4'h0;
  endtask

  task automatic sync(input logic [15:0] w);
    nib(w[15:12]);
    nib(w[11:8]);
    nib(w[7:4]);
    nib(w[3:0]);
  endtask

  task automatic send_bytes(input int base, input int from, input int to,
                            input bit expect_out);
    logic [7:0] b;
    for (int i = from; i <= to; i++) begin
      b = 8'(base + i);
      nib(b[7:4]);
      nib(b[3:0]);
      if (expect_out) begin
        exp_data.push_back(b);
        exp_last.push_back(i == QAM_FRAME_BYTES - 1);
      end
    end
  endtask

  task automatic do_reset();
    #1;
    axi_rst = 1'b1;
    @(posedge axi_clk);
    #1;
    axi_rst = 1'b0;
    rx_data.delete();
    rx_last.delete();
    exp_data.delete();
    exp_last.delete();
    ovf_cnt = 0;
  endtask

  task automatic compare(input string tag);
    int nl;
    repeat (6) @(posedge axi_clk);
    #1;
    chk({tag, "_count"}, rx_data.size(), exp_data.size());
    nl = 0;
    foreach (rx_last[i]) if (rx_last[i]) nl++;
    for (int i = 0; i < exp_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), {24'h0, rx_data[i]}, {24'h0, exp_data[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'h0, rx_last[i]}, {31'h0, exp_last[i]});
    end
    nl = nl;
  endtask

  function automatic int count_last();
    int n = 0;
    foreach (rx_last[i]) if (rx_last[i]) n++;
    return n;
  endfunction

  initial begin
    axi_rst       = 1'b1;
    din_valid     = 1'b0;
    din           = 4'h0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ovf", ovf, 0);
    axi_rst = 1'b0;
    do_reset();

    // basic frame, lock timing and first-byte latency
    nib(4'hE); nib(4'hB); nib(4'h9);
    chk("lock_before_4th", locked, 0);
    nib(4'h0);
    chk("lock_after_4th", locked, 1);
    nib(4'h0); nib(4'h0);
    exp_data.push_back(8'h00);
    exp_last.push_back(1'b0);
    chk("lat_tvalid_E", m_axis_tvalid, 0);
    @(posedge axi_clk);
    #1;
    chk("lat_tvalid_E1", m_axis_tvalid, 1);
    chk("lat_tdata_E1", m_axis_tdata, 8'h00);
    send_bytes(0, 1, 63, 1);
    compare("frame1");

    // noise then three back-to-back frames
    do_reset();
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4); nib(4'h5);
    chk("noise_unlocked", locked, 0);
    for (int f = 0; f < 3; f++) begin
      sync(16'hEB90);
      send_bytes(f * 64, 0, 63, 1);
    end
    compare("three");
    chk("three_tlast_cnt", count_last(), 3);
    chk("three_ovf", ovf_cnt, 0);

    // flywheel through two bad syncs, lose lock on the third
    do_reset();
    sync(16'hEB90);
    send_bytes(0, 0, 63, 1);
    sync(16'h0000);
    chk("miss1_locked", locked, 1);
    send_bytes(64, 0, 63, 1);
    sync(16'h0000);
    chk("miss2_locked", locked, 1);
    send_bytes(128, 0, 63, 1);
    nib(4'h0); nib(4'h0); nib(4'h0);
    chk("miss3_pre_locked", locked, 1);
    nib(4'h0);
    chk("miss3_locked", locked, 0);
    send_bytes(16'h55 - 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      nib(4'h5); nib(4'h5);
    end
    repeat (4) @(posedge axi_clk);
    #1;
    chk("unlocked_no_out", rx_data.size(), 192);
    chk("unlocked_still", locked, 0);
    sync(16'hEB90);
    chk("relock", locked, 1);
    send_bytes(200, 0, 63, 1);
    compare("miss");
`ifdef QAM_DEFRAMER_STATS_EN
    chk("stats_sync_loss", sync_loss_cnt, 1);
    chk("stats_frames_miss", frame_cnt, 4);
`endif

    // backpressure: 16 held, 4 dropped
    do_reset();
    m_axis_tready = 1'b0;
    sync(16'hEB90);
    send_bytes(0, 0, 19, 0);
    repeat (3) @(posedge axi_clk);
    #1;
    chk("bp_ovf_pulses", ovf_cnt, 4);
    chk("bp_tvalid", m_axis_tvalid, 1);
    chk("bp_tdata_hold", m_axis_tdata, 8'h00);
`ifdef QAM_DEFRAMER_STATS_EN
    chk("bp_drop_cnt", drop_cnt, 4);
`endif
    for (int i = 0; i < 16; i++) begin
      exp_data.push_back(8'(i));
      exp_last.push_back(1'b0);
    end
    m_axis_tready = 1'b1;
    send_bytes(0, 20, 63, 1);
    compare("bp");
    chk("bp_ovf_final", ovf_cnt, 4);

    // asynchronous reset mid-frame
    do_reset();
    m_axis_tready = 1'b0;
    sync(16'hEB90);
    send_bytes(8'h80, 0, 9, 0);
    nib(4'h8);
    chk("mid_tvalid_pre", m_axis_tvalid, 1);
    chk("mid_tdata_pre", m_axis_tdata, 8'h80);
    axi_rst = 1'b1;
    #1;
    chk("mid_tvalid_rst", m_axis_tvalid, 0);
    chk("mid_tdata_rst", m_axis_tdata, 0);
    chk("mid_locked_rst", locked, 0);
    @(posedge axi_clk);
    #1;
    axi_rst       = 1'b0;
    m_axis_tready = 1'b1;
    rx_data.delete();
    rx_last.delete();
    exp_data.delete();
    exp_last.delete();
    sync(16'hEB90);
    send_bytes(0, 0, 63, 1);
    compare("after_rst");

    // gapped input: one valid nibble every 3rd cycle
    do_reset();
    gap = 2;
    sync(16'hEB90);
    send_bytes(8'h40, 0, 63, 1);
    gap = 0;
    compare("gapped");
    chk("gapped_tlast_cnt", count_last(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
